// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring integer divider, signed/unsigned, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_en,
  input  logic               div_signed,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic             s1, s2;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CNT_W-1:0] cnt;

  logic             start;
  logic [WIDTH-1:0] mag_1, mag_2;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Accept a start only from IDLE with no flush; operands reduce to magnitudes
  always_comb begin
    start = (state == IDLE) && div_en && !cancel;
    mag_1 = (div_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    mag_2 = (div_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;
  end

  // Restoring step: bring in the next dividend bit and subtract if the divisor fits
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // Sign correction; with a zero divisor the quotient register still holds |dividend|
  always_comb begin
    if (dvs == '0) begin
      quo_fix = '1;
      rem_fix = s1 ? -quo : quo;
    end else begin
      quo_fix = (s1 ^ s2) ? -quo : quo;
      rem_fix = s1 ? -rem : rem;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; a flush overrides every transition
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (operand_2 == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (cancel) begin
      state_next = IDLE;
    end
  end

  // Operand capture, iteration, and result registration at the FIX edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      s1  <= div_signed & operand_1[WIDTH-1];
      s2  <= div_signed & operand_2[WIDTH-1];
      rem <= '0;
      quo <= mag_1;
      dvs <= mag_2;
      cnt <= CNT_W'(WIDTH);
    end else if (!cancel) begin
      if (state == CALC) begin
        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX) begin
        result      <= {rem_fix, quo_fix};
        div_by_zero <= (dvs == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against a latency/arithmetic model
module tb_seq_divider;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           div_en = 1'b0;
  logic           div_signed = 1'b0;
  logic           cancel = 1'b0;
  logic [W-1:0]   operand_1 = '0;
  logic [W-1:0]   operand_2 = '0;
  logic           busy, done, div_by_zero;
  logic [2*W-1:0] result;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_en     (div_en),
    .div_signed (div_signed),
    .cancel     (cancel),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .result     (result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state: cycles left until the done cycle is over (0 = idle)
  int             cyc = 0;
  int             left = 0;
  int             start_cyc = 0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic           exp_dz = 1'b0;
  logic [2*W-1:0] exp_result = '0;
  logic [2*W-1:0] pend_result = '0;
  logic           pend_dz = 1'b0;

  // hand-computed expectations attached to a directed operation
  logic           pin_arm = 1'b0;
  logic           pend_pin = 1'b0;
  logic           pin_on = 1'b0;
  logic [2*W-1:0] pin_result = '0;
  logic           pin_dz = 1'b0;
  int             pin_lat = 0;

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // advance the model over the clock edge that just happened, using the inputs held across it
  task automatic model_update();
    cyc++;
    pin_on = 1'b0;
    if (!rst_n) begin
      left       = 0;
      exp_result = '0;
      exp_dz     = 1'b0;
    end else if (cancel) begin
      left = 0;
    end else if (left > 0) begin
      left--;
      if (left == 1) begin
        exp_result = pend_result;
        exp_dz     = pend_dz;
        pin_on     = pend_pin;
      end
    end else if (div_en) begin
      pend_result = ref_div(operand_1, operand_2, div_signed);
      pend_dz     = (operand_2 == '0);
      pend_pin    = pin_arm;
      start_cyc   = cyc - 1;
      left        = pend_dz ? 2 : W + 2;
    end
    exp_busy = (left > 0);
    exp_done = (left == 1);
  endtask

  task automatic step(input logic en, input logic sgn, input logic cx,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    div_en     = en;
    div_signed = sgn;
    cancel     = cx;
    operand_1  = a;
    operand_2  = b;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom), 1'b0, W'($urandom), W'($urandom));
    end
  endtask

  task automatic run_pinned(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input logic [2*W-1:0] pr, input logic pdz, input int plat);
    pin_result = pr;
    pin_dz     = pdz;
    pin_lat    = plat;
    pin_arm    = 1'b1;
    step(1'b1, sgn, 1'b0, a, b);
    pin_arm = 1'b0;
    idle(W + 2);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, want);
    end
  endtask

  // compare DUT outputs with the model every cycle, and right after an asynchronous reset
  always @(negedge clk or negedge rst_n) begin
    #1;
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done", 64'(done), 64'(exp_done));
    chk("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
    chk("result", result, exp_result);
    if (pin_on) begin
      chk("pin_result", exp_result, pin_result);
      chk("pin_dz", 64'(exp_dz), 64'(pin_dz));
      chk("pin_latency", 64'(done ? cyc - start_cyc : 0), 64'(pin_lat));
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      model_update();
    end
    rst_n = 1'b1;
    idle(2);

    run_pinned(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0, 34);
    run_pinned(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 34);
    run_pinned(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 34);
    run_pinned(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b0, 34);
    run_pinned(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 1'b0, 34);
    run_pinned(32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, 2);
    run_pinned(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 1'b0, 34);
    run_pinned(32'hFFFF_FFFB, 32'h0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 2);

    // flush at cycle 10 of a division
    step(1'b1, 1'b0, 1'b0, 32'd1000, 32'd7);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    idle(5);

    // flush in the same cycle as a start request
    step(1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
    idle(3);

    // flush during the FIX cycle and during the DONE cycle
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FF00, 32'd3);
    idle(W);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd77, 32'd5);
    idle(W + 1);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    idle(2);

    // start requests held high throughout: one done per accepted start, back-to-back issue
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
    for (int i = 0; i < 2 * W + 8; i++) begin
      step(1'b1, 1'($urandom), 1'b0, rnd_op(), rnd_op());
    end
    idle(W + 3);

    // asynchronous reset between edges in the middle of a division
    step(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    idle(10);
    #2;
    left       = 0;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_dz     = 1'b0;
    exp_result = '0;
    pin_on     = 1'b0;
    rst_n      = 1'b0;
    idle(2);
    rst_n = 1'b1;
    run_pinned(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 1'b0, 34);

    // randomized traffic with sporadic flushes
    for (int i = 0; i < 6000; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 48) == 0, rnd_op(), rnd_op());
    end
    idle(W + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle iterative integer divider for the EX stage. It is the parametrised successor to the single-cycle array divider. It computes one quotient bit per clock on operand magnitudes, so the critical path is one WIDTH-bit subtractor instead of WIDTH chained CAS rows. It adds signed/unsigned selection, a start/busy/done handshake, pipeline-flush cancel, and defined divide-by-zero and overflow results. Results are packed as {remainder, quotient}, the same as the existing divider, so EX writeback muxing is unchanged.

## Interface
- WIDTH, default 32: operand width; must be ≥ 4.
- CNT_W, default $clog2(WIDTH+1): iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- div_en  in  1  start request; sampled only in IDLE.
- div_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with div_en.
- cancel  in  1  flush; aborts any operation in progress.
- operand_1  in  WIDTH  dividend; captured with div_en.
- operand_2  in  WIDTH  divisor; captured with div_en.
- busy  out  1  high from the capture edge until the cycle done is asserted.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- div_by_zero  out  1  set with done when operand_2 was 0; held with result.
- result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; held until the next done.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, with div_en=1 and cancel=0:
  - capture sign flags: s1 = div_signed & op1 MSB; s2 = div_signed & op2 MSB.
  - store magnitudes |op1| and |op2| as WIDTH-bit unsigned. |MIN| = 2^(W-1) is representable as unsigned.
  - clear the partial remainder; load cnt = WIDTH.
  - go to CALC, or go directly to FIX if operand_2 == 0.
- CALC, restoring step each cycle:
  - {r, q} shifts left 1 bit.
  - trial = r − |op2| on WIDTH+1 bits; if trial ≥ 0 then r = trial and q[0] = 1.
  - cnt decrements each cycle; when cnt reaches 1, the next state is FIX.
- FIX, sign correction:
  - quotient = (s1 ^ s2) ? −q : q.
  - remainder = s1 ? −r : r, so the remainder takes the dividend's sign and |rem| < |divisor|.
  - result is registered here; go to DONE.
- Divide by zero (in FIX): quotient = all ones; remainder = operand_1 as captured; div_by_zero = 1.
- Signed overflow, MIN / −1: quotient = MIN, remainder = 0, div_by_zero = 0. This falls out of the magnitude algorithm with no special case.
- DONE: done = 1 for one cycle, then unconditionally return to IDLE.
- div_en while busy is ignored and not queued.
- cancel, any state: next state is IDLE, busy drops next cycle, no done pulse, and result/div_by_zero keep their previous values. In IDLE, cancel=1 suppresses a simultaneous div_en.
- div_en sampled in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, result=0, state=IDLE, cnt=0.
- Normal latency: capture edge E0, CALC edges E1..E_WIDTH, FIX edge E_(WIDTH+1). done is high in the cycle after E_(WIDTH+1), which is WIDTH+2 cycles after div_en was sampled (34 for WIDTH=32).
- Divide-by-zero latency: done two cycles after capture.
- busy is high during every CALC, FIX and DONE cycle, so issue logic stalls on busy.
- Minimum issue interval: WIDTH+3 cycles.
- result and div_by_zero change only at the FIX edge.
- Reset asserted mid-operation: all outputs return to reset values immediately, with no clock needed.

## Test plan
- Unsigned, WIDTH=32: 100 / 7, div_signed=0 → done at cycle 34, result = {32'd2, 32'd14}, busy high cycles 1–34.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Same run with 7 / −2 → quotient −3, remainder +1.
- Overflow and unsigned extreme:
  - 0x80000000 / 0xFFFFFFFF, signed → quotient 0x80000000, remainder 0, div_by_zero=0.
  - Same operands unsigned → quotient 0, remainder 0x80000000.
- Divide by zero: 0x12345678 / 0 → done at cycle 2, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1; the flag clears on the next valid division's done.
- Cancel and handshake:
  - cancel at cycle 10 of a division → no done, busy low at cycle 11, result unchanged from the prior op.
  - div_en pulses while busy → ignored; exactly one done per accepted start.
- Async reset: assert rst_n=0 mid-CALC between clock edges → busy, done, result read 0 before the next edge; a division issued after release completes normally.
